// File: rtl/vote_session_ctrl.sv
// Majority-vote session sequencer: opens a ballot window, latches each voter's
// first vote, closes on all-voted or timeout, then tallies ballots one per cycle.
module vote_session_ctrl #(
  parameter int unsigned PERSON  = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [PERSON-1:0] cast_i,
  input  logic [PERSON-1:0] choice_i,
  output logic [PERSON-1:0] voted_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic              out_o,
  output logic [$clog2(PERSON+1)-1:0] yes_cnt_o,
  output logic              even_o
);

  localparam int unsigned CW      = $clog2(PERSON + 1);
  localparam int unsigned IW      = (PERSON > 1) ? $clog2(PERSON) : 1;
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned HALF    = PERSON / 2;
  localparam bit          IS_EVEN = (PERSON % 2) == 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPEN,
    S_TALLY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PERSON-1:0] voted_q, voted_d;
  logic [PERSON-1:0] ballot_q, ballot_d;
  logic [CW-1:0]     yes_q, yes_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  // Next-state and datapath update; abort overrides every state.
  always_comb begin
    state_d  = state_q;
    voted_d  = voted_q;
    ballot_d = ballot_q;
    yes_d    = yes_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    out_d    = out_q;

    if (abort_i) begin
      state_d  = S_IDLE;
      voted_d  = '0;
      ballot_d = '0;
      yes_d    = '0;
      timer_d  = '0;
      idx_d    = '0;
      out_d    = 1'b0;
    end else if (!IS_EVEN) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d  = S_OPEN;
            timer_d  = TW'(TIMEOUT - 1);
            voted_d  = '0;
            ballot_d = '0;
            yes_d    = '0;
            idx_d    = '0;
            out_d    = 1'b0;
          end
        end
        S_OPEN: begin
          // Only voters not yet latched may set their ballot bit.
          voted_d  = voted_q | cast_i;
          ballot_d = (ballot_q & voted_q) | (cast_i & ~voted_q & choice_i);
          if ((&voted_d) || (timer_q == '0)) begin
            state_d = S_TALLY;
            idx_d   = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_TALLY: begin
          yes_d = yes_q + CW'(ballot_q[idx_q]);
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(PERSON - 1)) begin
            state_d = S_DONE;
            idx_d   = '0;
            out_d   = (yes_d > CW'(HALF));
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d == S_OPEN) || (state_d == S_TALLY);
    valid_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      voted_q  <= '0;
      ballot_q <= '0;
      yes_q    <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      voted_q  <= voted_d;
      ballot_q <= ballot_d;
      yes_q    <= yes_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign voted_o   = voted_q;
  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign out_o     = out_q;
  assign yes_cnt_o = yes_q;
  assign even_o    = 1'(IS_EVEN);

endmodule
